// File: rtl/submatrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : submatrix_pkg
//  Description : Shared constants, state encoding and tile bit-index rule for
//                the submatrix creator / plotter pair. A tile is a 4x4 grid
//                of 1-bit pixels packed row-major into 16 bits, with bit 15
//                as the top-left pixel.
//  Ports       : (package - none)
//  Revision    : 1.0 - initial release
// ============================================================================
package submatrix_pkg;

    localparam int TILE_DIM  = 4;
    localparam int TILE_BITS = TILE_DIM * TILE_DIM;
    localparam int FRAME_W   = 160;
    localparam int FRAME_H   = 120;

    // Pixel bus widths sized from the frame so x/y never overflow.
    localparam int X_W      = $clog2(FRAME_W);
    localparam int Y_W      = $clog2(FRAME_H);
    localparam int COLOUR_W = 3;
    localparam int PIX_W    = $clog2(TILE_BITS);
    localparam int RC_W     = $clog2(TILE_DIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit of the tile word holding pixel (row r, column c): 15 - (4r + c).
    function automatic logic [PIX_W-1:0] tile_bit_index(
        input logic [RC_W-1:0] r,
        input logic [RC_W-1:0] c
    );
        return PIX_W'(TILE_BITS - 1) - {r, c};
    endfunction

endpackage
`default_nettype wire

// File: rtl/submatrix_plotter_if.sv
`default_nettype none
// ============================================================================
//  Module      : submatrix_plotter_if
//  Description : Tile handshake from the creator plus the VGA pixel write bus.
//                master = creator/VGA side, slave = plotter.
//  Signals     : dataIn[15:0], loaded          creator -> plotter
//                readyToBeLoaded               plotter -> creator
//                x[7:0], y[6:0], colour[2:0], plot   plotter -> VGA adapter
//  Revision    : 1.0 - initial release
// ============================================================================
interface submatrix_plotter_if;
    import submatrix_pkg::*;

    logic [TILE_BITS-1:0] dataIn;
    logic                 loaded;
    logic                 readyToBeLoaded;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [COLOUR_W-1:0]  colour;
    logic                 plot;

    modport master (
        output dataIn, loaded,
        input  readyToBeLoaded, x, y, colour, plot
    );

    modport slave (
        input  dataIn, loaded,
        output readyToBeLoaded, x, y, colour, plot
    );

endinterface
`default_nettype wire

// File: rtl/tile_position_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_position_counter
//  Description : Raster-order tile position (tileX, tileY). Each advance
//                pulse steps one tile right, wrapping to the next row at the
//                end of a row. last_tile flags the bottom-right tile.
//  Ports       : clk, resetn (sync, active-low), advance (in)
//                tile_x, tile_y, last_tile (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_position_counter #(
    parameter int TILES_X = 40,
    parameter int TILES_Y = 30,
    parameter int TXW     = 6,
    parameter int TYW     = 5
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    input  wire logic           advance,
    output logic [TXW-1:0]      tile_x,
    output logic [TYW-1:0]      tile_y,
    output logic                last_tile
);

    logic [TXW-1:0] tile_x_q, tile_x_d;
    logic [TYW-1:0] tile_y_q, tile_y_d;
    logic           x_at_end;
    logic           y_at_end;

    assign x_at_end = (tile_x_q == TXW'(TILES_X - 1));
    assign y_at_end = (tile_y_q == TYW'(TILES_Y - 1));

    always_comb begin
        tile_x_d = tile_x_q;
        tile_y_d = tile_y_q;
        if (advance) begin
            if (x_at_end) begin
                tile_x_d = '0;
                tile_y_d = y_at_end ? '0 : tile_y_q + TYW'(1);
            end else begin
                tile_x_d = tile_x_q + TXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tile_x_q <= '0;
            tile_y_q <= '0;
        end else begin
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
        end
    end

    assign tile_x    = tile_x_q;
    assign tile_y    = tile_y_q;
    assign last_tile = x_at_end && y_at_end;

endmodule
`default_nettype wire

// File: rtl/submatrix_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : submatrix_plotter
//  Description : Accepts 16-bit 4x4 tiles over the loaded/readyToBeLoaded
//                handshake and writes each one pixel by pixel to the VGA
//                adapter, placing tiles in raster order over a 160x120 frame.
//  Ports       : clk, resetn (sync, active-low), enable (global run)
//                bus (slave): dataIn, loaded -> readyToBeLoaded,
//                             x, y, colour, plot
//                done (out)   sticky: every tile of the frame drawn
//  Revision    : 1.0 - initial release
// ============================================================================
module submatrix_plotter
    import submatrix_pkg::*;
#(
    parameter int                  TILES_X   = 40,
    parameter int                  TILES_Y   = 30,
    parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    input  wire logic           enable,
    submatrix_plotter_if.slave  bus,
    output logic                done
);

    localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

    state_e               state_q, state_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [TILE_BITS-1:0] tile_q, tile_d;
    logic                 advance;

    logic [TXW-1:0]       tile_x;
    logic [TYW-1:0]       tile_y;
    logic                 last_tile;

    logic [RC_W-1:0]      row;
    logic [RC_W-1:0]      col;
    logic                 src_bit;

    tile_position_counter #(
        .TILES_X (TILES_X),
        .TILES_Y (TILES_Y),
        .TXW     (TXW),
        .TYW     (TYW)
    ) u_pos (
        .clk       (clk),
        .resetn    (resetn),
        .advance   (advance),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .last_tile (last_tile)
    );

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        tile_d  = tile_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.loaded && enable) begin
                    tile_d  = bus.dataIn;
                    pix_d   = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                // A low enable freezes pix, tile and position in place.
                if (enable) begin
                    pix_d = pix_q + PIX_W'(1);
                    if (pix_q == PIX_W'(TILE_BITS - 1)) begin
                        advance = 1'b1;
                        state_d = last_tile ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pix_q   <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            tile_q  <= tile_d;
        end
    end

    // Pixel decode from registered state only; {tile, rc} is 4*tile + rc.
    assign row     = pix_q[PIX_W-1:RC_W];
    assign col     = pix_q[RC_W-1:0];
    assign src_bit = tile_q[tile_bit_index(row, col)];

    assign bus.readyToBeLoaded = (state_q == ST_IDLE);
    assign bus.plot            = (state_q == ST_DRAW) && enable;
    assign done                = (state_q == ST_DONE);
    assign bus.x               = X_W'({tile_x, col});
    assign bus.y               = Y_W'({tile_y, row});
    assign bus.colour          = ((state_q == ST_DRAW) && src_bit) ? FG_COLOUR : BG_COLOUR;

endmodule
`default_nettype wire

// File: tb/tb_submatrix_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_submatrix_plotter
//  Description : Self-checking bench for submatrix_plotter. Expected pixel
//                positions and colours come from a raster-order tile model
//                (tile index -> x/y, word bit -> colour).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_submatrix_plotter;

    localparam int         TX = 40;
    localparam int         TY = 30;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic enable = 1'b0;
    logic done;

    submatrix_plotter_if bus ();

    submatrix_plotter #(
        .TILES_X   (TX),
        .TILES_Y   (TY),
        .FG_COLOUR (FG),
        .BG_COLOUR (BG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .bus    (bus),
        .done   (done)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int exp_idx = 0;

    typedef struct {
        logic [15:0] word;
        int          stall_at;
        int          stall_len;
        bit          poke;
        int          exp_cycles;
        int          exp_fg;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tile %0d, t=%0t)", name, act, req, exp_idx, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  int'(bus.readyToBeLoaded), 1);
        chk({tag, "_plot"},   int'(bus.plot), 0);
        chk({tag, "_done"},   int'(done), 0);
        chk({tag, "_x"},      int'(bus.x), 0);
        chk({tag, "_y"},      int'(bus.y), 0);
        chk({tag, "_colour"}, int'(bus.colour), int'(BG));
    endtask

    // Called just after a falling edge with the DUT expected in IDLE. Offers
    // one tile, then walks and checks every cycle of its drawing.
    task automatic run_tile(input logic [15:0] word, input int stall_at, input int stall_len,
                            input bit poke, input int abort_at,
                            output int cycles, output int fg);
        int stalls;
        int p;
        int ex, ey;
        logic [2:0] ec;
        cycles = 0;
        fg     = 0;
        stalls = 0;
        p      = 0;
        bus.loaded = 1'b1;
        bus.dataIn = word;
        enable     = 1'b1;
        #1;
        chk("ready_before_accept", int'(bus.readyToBeLoaded), 1);
        @(negedge clk);
        cycles = 1;
        while (p < 16 && cycles < 64) begin
            bus.loaded = poke && (p == 3);
            bus.dataIn = (poke && p == 3) ? ~word : 16'($urandom);
            if (p == stall_at && stalls < stall_len) begin
                enable = 1'b0;
                stalls++;
            end else begin
                enable = 1'b1;
            end
            if (p == abort_at) begin
                enable     = 1'b1;
                bus.loaded = 1'b0;
                resetn     = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                #1;
                chk_reset_outputs("abort");
                exp_idx = 0;
                return;
            end
            #1;
            chk("ready_in_draw", int'(bus.readyToBeLoaded), 0);
            if (enable) begin
                ex = 4 * (exp_idx % TX) + (p % 4);
                ey = 4 * (exp_idx / TX) + (p / 4);
                ec = word[15 - p] ? FG : BG;
                chk("plot", int'(bus.plot), 1);
                chk("x", int'(bus.x), ex);
                chk("y", int'(bus.y), ey);
                chk("colour", int'(bus.colour), int'(ec));
                if (bus.colour == FG) fg++;
                p++;
            end else begin
                chk("plot_stalled", int'(bus.plot), 0);
            end
            @(negedge clk);
            cycles++;
        end
        enable     = 1'b1;
        bus.loaded = 1'b0;
        #1;
        if (p < 16) chk("draw_timeout_pixels", p, 16);
        if (exp_idx == TX * TY - 1) begin
            chk("done_after_last", int'(done), 1);
            chk("ready_after_last", int'(bus.readyToBeLoaded), 0);
        end else begin
            chk("ready_after_tile", int'(bus.readyToBeLoaded), 1);
            chk("done_mid_frame", int'(done), 0);
        end
        exp_idx++;
    endtask

    initial begin
        int cyc, fg;
        tbl[0] = '{word: 16'h8001, stall_at: -1, stall_len: 0, poke: 1'b0, exp_cycles: 17, exp_fg: 2};
        tbl[1] = '{word: 16'hFFFF, stall_at: -1, stall_len: 0, poke: 1'b0, exp_cycles: 17, exp_fg: 16};
        tbl[2] = '{word: 16'h00F0, stall_at: 5,  stall_len: 3, poke: 1'b0, exp_cycles: 20, exp_fg: 4};
        tbl[3] = '{word: 16'h1234, stall_at: -1, stall_len: 0, poke: 1'b1, exp_cycles: 17, exp_fg: 5};

        bus.loaded = 1'b0;
        bus.dataIn = 16'h0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            run_tile(tbl[i].word, tbl[i].stall_at, tbl[i].stall_len, tbl[i].poke, -1, cyc, fg);
            chk("tile_cycles", cyc, tbl[i].exp_cycles);
            chk("tile_fg_count", fg, tbl[i].exp_fg);
        end

        // Reset mid-tile: the following tile must start again at (0,0).
        run_tile(16'hA5A5, -1, 0, 1'b0, 9, cyc, fg);

        for (int t = 0; t < TX * TY; t++) begin
            int sa, sl;
            bit pk;
            sa = -1;
            sl = 0;
            if ($urandom_range(0, 7) == 0) begin
                sa = int'($urandom_range(0, 15));
                sl = int'($urandom_range(1, 3));
            end
            pk = ($urandom_range(0, 3) == 0);
            run_tile(16'($urandom), sa, sl, pk, -1, cyc, fg);
            chk("rand_tile_cycles", cyc, 17 + sl);
        end

        // Frame complete: further offers are ignored and done stays high.
        for (int i = 0; i < 4; i++) begin
            bus.loaded = 1'b1;
            bus.dataIn = 16'($urandom);
            enable     = 1'b1;
            @(negedge clk);
            #1;
            chk("done_sticky", int'(done), 1);
            chk("ready_in_done", int'(bus.readyToBeLoaded), 0);
            chk("plot_in_done", int'(bus.plot), 0);
        end
        bus.loaded = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
